// File: rtl/out_pkg.sv
// Shared types and defaults for the 7-segment output write path.
// Slot/data widths here must match the output block that consumes them.
package out_pkg;

    localparam int SLOT_W_DEF = 3;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2
    } arb_state_t;

    // Index width never collapses to 0, so a single requester still has a 1-bit id.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/out_write_arbiter_if.sv
// Requester-side and output-block-side signals of the display write arbiter.
// master = requesters/output block view, slave = arbiter view.
interface out_write_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int SLOT_W = out_pkg::SLOT_W_DEF,
    parameter int DATA_W = out_pkg::DATA_W_DEF
);
    import out_pkg::*;

    localparam int IDX_W = idx_w(NREQ);

    logic [NREQ-1:0]        req;
    logic [NREQ*SLOT_W-1:0] req_sel;
    logic [NREQ*DATA_W-1:0] req_val1;
    logic [NREQ*DATA_W-1:0] req_val2;
    logic [NREQ-1:0]        ack;
    logic [DATA_W-1:0]      outval1;
    logic [DATA_W-1:0]      outval2;
    logic [SLOT_W-1:0]      outsel;
    logic                   outdisplay;
    logic                   busy;
    logic [IDX_W-1:0]       grant_id;

    modport master (
        output req, req_sel, req_val1, req_val2,
        input  ack, outval1, outval2, outsel, outdisplay, busy, grant_id
    );

    modport slave (
        input  req, req_sel, req_val1, req_val2,
        output ack, outval1, outval2, outsel, outdisplay, busy, grant_id
    );

endinterface

// File: rtl/out_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after i_ptr, wrapping modulo NREQ.
// Zero latency; o_vld low when no request is pending.
module rr_pick
    import out_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_vld,
    output logic [IDX_W-1:0] o_idx
);

    int w_j;

    // Scan from the farthest offset down so the nearest hit is written last and wins.
    always_comb begin
        o_vld = 1'b0;
        o_idx = '0;
        w_j   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (i_req[w_j]) begin
                o_vld = 1'b1;
                o_idx = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/out_write_arbiter.sv
// Round-robin share of the display write port; grant->strobe 2 edges, one write per 3 cycles.
// req is a level held until ack; OUT_ARB_PRIO_EN gives requester 0 fixed top priority.
module out_write_arbiter
    import out_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int SLOT_W = SLOT_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    out_write_arbiter_if.slave bus
);

    localparam int IDX_W = idx_w(NREQ);

    arb_state_t        r_state;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_grant_id;
    logic [NREQ-1:0]   r_ack;
    logic [DATA_W-1:0] r_outval1;
    logic [DATA_W-1:0] r_outval2;
    logic [SLOT_W-1:0] r_outsel;
    logic              r_outdisplay;
    logic              r_busy;

    logic [NREQ-1:0]   w_rr_req;
    logic              w_rr_vld;
    logic [IDX_W-1:0]  w_rr_idx;
    logic              w_vld;
    logic [IDX_W-1:0]  w_g;
    logic [IDX_W-1:0]  w_ptr_nxt;

`ifdef OUT_ARB_PRIO_EN
    // Requester 0 bypasses the rotation; the others keep rotating among themselves.
    assign w_rr_req = bus.req & ~NREQ'(1);
    assign w_vld    = bus.req[0] | w_rr_vld;
    assign w_g      = bus.req[0] ? '0 : w_rr_idx;
`else
    assign w_rr_req = bus.req;
    assign w_vld    = w_rr_vld;
    assign w_g      = w_rr_idx;
`endif

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req (w_rr_req),
        .i_ptr (r_rr_ptr),
        .o_vld (w_rr_vld),
        .o_idx (w_rr_idx)
    );

    // Wrap is modulo NREQ, not modulo 2^IDX_W.
    assign w_ptr_nxt = (r_grant_id == IDX_W'(NREQ - 1)) ? '0 : r_grant_id + IDX_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_ack        <= '0;
            r_outval1    <= '0;
            r_outval2    <= '0;
            r_outsel     <= '0;
            r_outdisplay <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack        <= '0;
                    r_outdisplay <= 1'b0;
                    if (w_vld) begin
                        r_outsel   <= bus.req_sel[int'(w_g)*SLOT_W +: SLOT_W];
                        r_outval1  <= bus.req_val1[int'(w_g)*DATA_W +: DATA_W];
                        r_outval2  <= bus.req_val2[int'(w_g)*DATA_W +: DATA_W];
                        r_grant_id <= w_g;
                        r_busy     <= 1'b1;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    r_outdisplay <= 1'b1;
                    r_ack        <= NREQ'(1) << r_grant_id;
`ifdef OUT_ARB_PRIO_EN
                    if (r_grant_id != '0) begin
                        r_rr_ptr <= w_ptr_nxt;
                    end
`else
                    r_rr_ptr <= w_ptr_nxt;
`endif
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    // Gap cycle: req is not looked at so the acked requester can drop it.
                    r_outdisplay <= 1'b0;
                    r_ack        <= '0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_outdisplay <= 1'b0;
                    r_ack        <= '0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack        = r_ack;
    assign bus.outval1    = r_outval1;
    assign bus.outval2    = r_outval2;
    assign bus.outsel     = r_outsel;
    assign bus.outdisplay = r_outdisplay;
    assign bus.busy       = r_busy;
    assign bus.grant_id   = r_grant_id;

endmodule

// File: tb/tb_out_write_arbiter.sv
// Directed bench for out_write_arbiter with hand-computed expected values.
module tb_out_write_arbiter;

    localparam int NREQ   = 4;
    localparam int SLOT_W = 3;
    localparam int DATA_W = 16;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    out_write_arbiter_if #(.NREQ(NREQ), .SLOT_W(SLOT_W), .DATA_W(DATA_W)) bus ();

    out_write_arbiter #(
        .NREQ   (NREQ),
        .SLOT_W (SLOT_W),
        .DATA_W (DATA_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] sel, input logic [15:0] v1,
                           input logic [15:0] v2);
        bus.req_sel[i*SLOT_W +: SLOT_W]  = sel;
        bus.req_val1[i*DATA_W +: DATA_W] = v1;
        bus.req_val2[i*DATA_W +: DATA_W] = v2;
        bus.req[i]                       = 1'b1;
    endtask

    // Advances at least one negedge, then until outdisplay is seen; returns negedges taken.
    task automatic wait_strobe(input string tag, output int cyc);
        @(negedge clock);
        cyc = 1;
        while (bus.outdisplay !== 1'b1 && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        if (bus.outdisplay !== 1'b1) begin
            chk({tag, "_timeout"}, 32'(bus.outdisplay), 32'd1);
        end
    endtask

    task automatic count_strobes(input int ncyc, output int cnt);
        cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clock);
            if (bus.outdisplay === 1'b1) cnt++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int cyc;
        int cnt;
        int exp_g;
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.req       = '0;
        bus.req_sel   = '0;
        bus.req_val1  = '0;
        bus.req_val2  = '0;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        chk("rst_outdisplay", 32'(bus.outdisplay), 32'd0);
        chk("rst_ack",        32'(bus.ack),        32'd0);
        chk("rst_outval1",    32'(bus.outval1),    32'd0);
        chk("rst_outval2",    32'(bus.outval2),    32'd0);
        chk("rst_outsel",     32'(bus.outsel),     32'd0);
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_grant_id",   32'(bus.grant_id),   32'd0);
        reset = 1'b0;
        count_strobes(20, cnt);
        chk("idle_no_strobe", 32'(cnt), 32'd0);

        // Single request from requester 2
        set_req(2, 3'd5, 16'h1234, 16'hABCD);
        @(negedge clock);
        chk("single_load_strobe", 32'(bus.outdisplay), 32'd0);
        chk("single_load_busy",   32'(bus.busy),       32'd1);
        @(negedge clock);
        chk("single_strobe",   32'(bus.outdisplay), 32'd1);
        chk("single_ack",      32'(bus.ack),        32'h4);
        chk("single_outsel",   32'(bus.outsel),     32'd5);
        chk("single_outval1",  32'(bus.outval1),    32'h1234);
        chk("single_outval2",  32'(bus.outval2),    32'hABCD);
        chk("single_grant_id", 32'(bus.grant_id),   32'd2);
        bus.req[2] = 1'b0;
        @(negedge clock);
        chk("single_strobe_drop", 32'(bus.outdisplay), 32'd0);
        chk("single_ack_drop",    32'(bus.ack),        32'd0);
        chk("single_hold_val1",   32'(bus.outval1),    32'h1234);
        count_strobes(10, cnt);
        chk("single_one_pulse", 32'(cnt), 32'd0);

        // All four held: rotation and 3-cycle cadence
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 3'(7 - i), 16'(16'h1000 + i), 16'(16'hA000 + i));
        end
        for (int w = 0; w < 12; w++) begin
            wait_strobe("rot", cyc);
`ifdef OUT_ARB_PRIO_EN
            exp_g = 0;
`else
            exp_g = w % NREQ;
`endif
            chk($sformatf("rot%0d_ack", w),      32'(bus.ack),      32'(1 << exp_g));
            chk($sformatf("rot%0d_grant", w),    32'(bus.grant_id), 32'(exp_g));
            chk($sformatf("rot%0d_outsel", w),   32'(bus.outsel),   32'(7 - exp_g));
            chk($sformatf("rot%0d_outval1", w),  32'(bus.outval1),  32'(16'h1000 + exp_g));
            chk($sformatf("rot%0d_gap", w),      32'(cyc),          (w == 0) ? 32'd2 : 32'd3);
        end
        bus.req = '0;

        // Set rr_ptr = 2 with a lone grant to requester 1, then race 1 and 3
        set_req(1, 3'd1, 16'h0011, 16'h0022);
        wait_strobe("ptr_setup", cyc);
        chk("ptr_setup_ack", 32'(bus.ack), 32'h2);
        bus.req[1] = 1'b0;
        set_req(1, 3'd2, 16'h1111, 16'h2222);
        set_req(3, 3'd6, 16'h3333, 16'h4444);
        wait_strobe("race_first", cyc);
        chk("race_first_ack",    32'(bus.ack),     32'h8);
        chk("race_first_outsel", 32'(bus.outsel),  32'd6);
        bus.req[3] = 1'b0;
        wait_strobe("race_second", cyc);
        chk("race_second_ack",     32'(bus.ack),     32'h2);
        chk("race_second_outval2", 32'(bus.outval2), 32'h2222);
        bus.req[1] = 1'b0;
        count_strobes(10, cnt);
        chk("race_no_extra", 32'(cnt), 32'd0);

        // Reset during LOAD of a grant to requester 1 (rr_ptr is 2 here)
        set_req(1, 3'd3, 16'h5555, 16'h6666);
        @(negedge clock);
        chk("abort_in_load", 32'(bus.busy), 32'd1);
        reset      = 1'b1;
        bus.req[1] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_outdisplay", 32'(bus.outdisplay), 32'd0);
        chk("abort_ack",        32'(bus.ack),        32'd0);
        chk("abort_outsel",     32'(bus.outsel),     32'd0);
        chk("abort_outval1",    32'(bus.outval1),    32'd0);
        chk("abort_busy",       32'(bus.busy),       32'd0);
        chk("abort_grant_id",   32'(bus.grant_id),   32'd0);
        chk("abort_rr_ptr",     32'(dut.r_rr_ptr),   32'd0);
        count_strobes(10, cnt);
        chk("abort_no_strobe", 32'(cnt), 32'd0);
        // A pointer left at 2 would pick requester 3 here
        set_req(0, 3'd4, 16'h0A0A, 16'h0B0B);
        set_req(3, 3'd7, 16'h0C0C, 16'h0D0D);
        wait_strobe("post_abort", cyc);
        chk("post_abort_ack", 32'(bus.ack), 32'h1);
        bus.req = '0;
        count_strobes(5, cnt);

        // Requesters 0 and 2 held together
        set_req(0, 3'd0, 16'h0F00, 16'h0F01);
        set_req(2, 3'd2, 16'h0F20, 16'h0F21);
        for (int w = 0; w < 4; w++) begin
            wait_strobe("pair", cyc);
`ifdef OUT_ARB_PRIO_EN
            exp_g = 0;
`else
            exp_g = (w % 2 == 0) ? 2 : 0;
`endif
            chk($sformatf("pair%0d_ack", w), 32'(bus.ack), 32'(1 << exp_g));
        end
        bus.req[0] = 1'b0;
        wait_strobe("pair_drop0", cyc);
        chk("pair_drop0_ack",  32'(bus.ack),      32'h4);
        chk("pair_drop0_gap",  32'(cyc),          32'd3);
        chk("pair_drop0_val1", 32'(bus.outval1),  32'h0F20);
        bus.req = '0;
        count_strobes(5, cnt);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
